// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and formatting helpers for the load/store alignment unit.
package lsu_pkg;

  localparam int unsigned MAX_XLEN = 64;
  localparam int unsigned MAX_NB   = MAX_XLEN / 8;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_D = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    BEAT0 = 2'b01,
    BEAT1 = 2'b10,
    DONE  = 2'b11
  } state_e;

  // Two-beat byte-enable mask: low NB bits are beat 0, next NB bits beat 1.
  function automatic logic [2*MAX_NB-1:0] be_mask(input size_e size, input logic [2:0] off,
                                                  input int unsigned nb);
    logic [2*MAX_NB-1:0] m;
    logic [2*MAX_NB-1:0] clip;
    case (size)
      SZ_B:    m = 16'h0001;
      SZ_H:    m = 16'h0003;
      SZ_W:    m = 16'h000F;
      default: m = 16'h00FF;
    endcase
    m = m << off;
    if (nb >= MAX_NB) clip = '1;
    else              clip = (16'(1) << (2 * nb)) - 16'(1);
    return m & clip;
  endfunction

  function automatic logic [MAX_XLEN-1:0] extend(input logic [MAX_XLEN-1:0] data,
                                                 input size_e size, input logic uns);
    logic [MAX_XLEN-1:0] r;
    case (size)
      SZ_B:    r = uns ? MAX_XLEN'(data[7:0])  : {{(MAX_XLEN-8){data[7]}}, data[7:0]};
      SZ_H:    r = uns ? MAX_XLEN'(data[15:0]) : {{(MAX_XLEN-16){data[15]}}, data[15:0]};
      SZ_W:    r = uns ? MAX_XLEN'(data[31:0]) : {{(MAX_XLEN-32){data[31]}}, data[31:0]};
      default: r = data;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lsu_align_unit_load_align.sv
// lsu_load_align: assembles load bytes in address order from two lane words and extends them.
module lsu_load_align
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] lo_i,
  input  logic [XLEN-1:0] hi_i,
  input  logic [2:0]      off_i,
  input  logic [1:0]      size_i,
  input  logic            unsigned_i,
  output logic [XLEN-1:0] data_o
);

  logic [XLEN-1:0] lanes;

  always_comb begin
    lanes  = XLEN'({hi_i, lo_i} >> (8 * off_i));
    data_o = XLEN'(extend(MAX_XLEN'(lanes), size_e'(size_i), unsigned_i));
  end

endmodule

// File: rtl/lsu_align_unit.sv
// lsu_align_unit: byte-enable generation, lane shifting/extension and cache handshake.
// Define LSU_MISALIGN_SPLIT_EN to execute misaligned accesses (two beats when crossing a word).
module lsu_align_unit
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              busy,
  output logic              rsp_valid,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN/8-1:0] mem_be,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_ack,
  input  logic [XLEN-1:0]   mem_rdata
);

  localparam int unsigned NB    = XLEN / 8;
  localparam int unsigned OFF_W = $clog2(NB);

`ifdef LSU_MISALIGN_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  size_e             size_q, size_d;
  logic              we_q, we_d;
  logic              uns_q, uns_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [XLEN-1:0]   lo_q, lo_d;

  logic              req_ready_q, req_ready_d;
  logic              busy_q, busy_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [XLEN-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [NB-1:0]     mem_be_q, mem_be_d;
  logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;

  logic [2:0]        align_m;
  logic              illegal;
  logic              misaligned;
  logic [ADDR_W-1:0] base;
  logic [2*NB-1:0]   mask;
  logic [2*XLEN-1:0] wsh;
  logic [XLEN-1:0]   ld_lo;
  logic [XLEN-1:0]   ld_data;

  function automatic logic crosses(input logic [OFF_W-1:0] o, input size_e s);
    return (4'(o) + (4'd1 << s)) > 4'(NB);
  endfunction

  // Beat 0 data arrives on mem_rdata in the same cycle it is needed for a single-beat load.
  assign ld_lo = (state_q == BEAT0) ? mem_rdata : lo_q;

  lsu_load_align #(.XLEN(XLEN)) u_load_align (
    .lo_i       (ld_lo),
    .hi_i       (mem_rdata),
    .off_i      (3'(addr_q[OFF_W-1:0])),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .data_o     (ld_data)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    size_d      = size_q;
    we_d        = we_q;
    uns_d       = uns_q;
    wdata_d     = wdata_q;
    lo_d        = lo_q;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    mem_req_d   = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    mem_be_d    = '0;
    mem_wdata_d = '0;

    case (size_e'(req_size))
      SZ_B:    align_m = 3'b000;
      SZ_H:    align_m = 3'b001;
      SZ_W:    align_m = 3'b011;
      default: align_m = 3'b111;
    endcase
    illegal    = (size_e'(req_size) == SZ_D) && (XLEN != 64);
    misaligned = |(req_addr[2:0] & align_m);

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          size_d  = size_e'(req_size);
          we_d    = req_we;
          uns_d   = req_unsigned;
          wdata_d = req_wdata;
          if (illegal || (misaligned && !SPLIT_EN)) begin
            state_d   = DONE;
            rsp_err_d = 1'b1;
          end else begin
            state_d = BEAT0;
          end
        end
      end
      BEAT0: begin
        if (mem_ack) begin
          lo_d = mem_rdata;
`ifdef LSU_MISALIGN_SPLIT_EN
          if (crosses(addr_q[OFF_W-1:0], size_q)) begin
            state_d = BEAT1;
          end else begin
            state_d     = DONE;
            rsp_rdata_d = we_q ? '0 : ld_data;
          end
`else
          state_d     = DONE;
          rsp_rdata_d = we_q ? '0 : ld_data;
`endif
        end
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      BEAT1: begin
        if (mem_ack) begin
          state_d     = DONE;
          rsp_rdata_d = we_q ? '0 : ld_data;
        end
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Mem-side outputs are registered from the next state and next fields.
    base = {addr_d[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    mask = (2*NB)'(be_mask(size_d, 3'(addr_d[OFF_W-1:0]), NB));
    wsh  = (2*XLEN)'(wdata_d) << (8 * addr_d[OFF_W-1:0]);
    if (state_d == BEAT0) begin
      mem_req_d   = 1'b1;
      mem_we_d    = we_d;
      mem_addr_d  = base;
      mem_be_d    = mask[NB-1:0];
      mem_wdata_d = wsh[XLEN-1:0];
    end else if (state_d == BEAT1) begin
      mem_req_d   = 1'b1;
      mem_we_d    = we_d;
      mem_addr_d  = base + ADDR_W'(NB);
      mem_be_d    = mask[2*NB-1:NB];
      mem_wdata_d = wsh[2*XLEN-1:XLEN];
    end

    req_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
    rsp_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      size_q      <= SZ_B;
      we_q        <= 1'b0;
      uns_q       <= 1'b0;
      wdata_q     <= '0;
      lo_q        <= '0;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      size_q      <= size_d;
      we_q        <= we_d;
      uns_q       <= uns_d;
      wdata_q     <= wdata_d;
      lo_q        <= lo_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign req_ready = req_ready_q;
  assign busy      = busy_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_lsu_align_unit.sv
// tb_lsu_align_unit: table-driven scoreboard bench for lsu_align_unit (XLEN=32).
module tb_lsu_align_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        busy, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  lsu_align_unit #(.XLEN(32), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .busy(busy), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          nbeats;
    int          wt;
    logic [31:0] a0; logic [3:0] be0; logic [31:0] wd0; logic [31:0] rd0;
    logic [31:0] a1; logic [3:0] be1; logic [31:0] wd1; logic [31:0] rd1;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  rsp_t sb[$];
  vec_t vt[16];
  int   nv = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [1:0] sz, input logic uns,
      input logic [31:0] addr, input logic [31:0] wdata, input int nb, input int wt,
      input logic [31:0] a0, input logic [3:0] be0, input logic [31:0] wd0, input logic [31:0] rd0,
      input logic [31:0] a1, input logic [3:0] be1, input logic [31:0] wd1, input logic [31:0] rd1,
      input logic [31:0] exp_rd, input logic exp_err);
    vec_t v;
    v.we = we; v.size = sz; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.nbeats = nb; v.wt = wt;
    v.a0 = a0; v.be0 = be0; v.wd0 = wd0; v.rd0 = rd0;
    v.a1 = a1; v.be1 = be1; v.wd1 = wd1; v.rd1 = rd1;
    v.exp_rd = exp_rd; v.exp_err = exp_err;
    return v;
  endfunction

  task automatic add(input vec_t v);
    vt[nv] = v;
    nv++;
  endtask

  task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
    int c;
    c = 0;
    while (!req_ready && c < 20) begin
      @(posedge clk); #1;
      c++;
    end
    check("ready_before_issue", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int   beat, wcnt;
    bit   done;
    rsp_t e;
    issue(v.we, v.size, v.uns, v.addr, v.wdata);
    sb.push_back('{rdata: v.exp_rd, err: v.exp_err});
    beat = 0; wcnt = 0; done = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      mem_ack = 1'b0;
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL v%0d unexpected_rsp: got rsp_valid with empty scoreboard", id);
        end else begin
          e = sb.pop_front();
          check($sformatf("v%0d rdata", id), rsp_rdata, e.rdata);
          check($sformatf("v%0d err", id), 32'(rsp_err), 32'(e.err));
        end
        check($sformatf("v%0d beats", id), 32'(beat), 32'(v.nbeats));
        check($sformatf("v%0d latency", id), 32'(c), 32'(v.nbeats * (v.wt + 1)));
        done = 1'b1;
      end else if (mem_req) begin
        check($sformatf("v%0d b%0d addr", id, beat), mem_addr, (beat == 0) ? v.a0 : v.a1);
        check($sformatf("v%0d b%0d be", id, beat), 32'(mem_be), 32'((beat == 0) ? v.be0 : v.be1));
        check($sformatf("v%0d b%0d we", id, beat), 32'(mem_we), 32'(v.we));
        if (v.we) check($sformatf("v%0d b%0d wdata", id, beat), mem_wdata,
                        (beat == 0) ? v.wd0 : v.wd1);
        if (wcnt == v.wt) begin
          mem_ack   = 1'b1;
          mem_rdata = (beat == 0) ? v.rd0 : v.rd1;
          beat++;
          wcnt = 0;
        end else begin
          wcnt++;
        end
      end
      if (!done) begin
        @(posedge clk); #1;
      end
    end
    mem_ack = 1'b0;
    if (!done) begin
      n_checks++; n_errors++;
      $display("FAIL v%0d timeout: got no rsp_valid expected one within 60 cycles", id);
      void'(sb.pop_back());
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst req_ready", 32'(req_ready), 32'd1);
    check("rst busy", 32'(busy), 32'd0);
    check("rst rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst rsp_rdata", rsp_rdata, 32'd0);
    check("rst rsp_err", 32'(rsp_err), 32'd0);
    check("rst mem_req", 32'(mem_req), 32'd0);
    check("rst mem_we", 32'(mem_we), 32'd0);
    check("rst mem_addr", mem_addr, 32'd0);
    check("rst mem_be", 32'(mem_be), 32'd0);
    check("rst mem_wdata", mem_wdata, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Cycle-exact aligned LW: mem_req in cycle 1, rsp_valid in 2, req_ready in 3.
    issue(1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0);
    check("lw c1 mem_req", 32'(mem_req), 32'd1);
    check("lw c1 mem_be", 32'(mem_be), 32'hF);
    check("lw c1 mem_addr", mem_addr, 32'h100);
    check("lw c1 req_ready", 32'(req_ready), 32'd0);
    check("lw c1 busy", 32'(busy), 32'd1);
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    check("lw c2 rsp_valid", 32'(rsp_valid), 32'd1);
    check("lw c2 rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
    check("lw c2 mem_req", 32'(mem_req), 32'd0);
    check("lw c2 req_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    check("lw c3 rsp_valid", 32'(rsp_valid), 32'd0);
    check("lw c3 req_ready", 32'(req_ready), 32'd1);
    check("lw c3 busy", 32'(busy), 32'd0);

    add(mk(0, 2'b10, 0, 32'h100, 32'h0, 1, 0, 32'h100, 4'hF, 32'h0, 32'hDEADBEEF,
           32'h0, 4'h0, 32'h0, 32'h0, 32'hDEADBEEF, 0));
    add(mk(0, 2'b00, 0, 32'h103, 32'h0, 1, 0, 32'h100, 4'h8, 32'h0, 32'h80000000,
           32'h0, 4'h0, 32'h0, 32'h0, 32'hFFFFFF80, 0));
    add(mk(0, 2'b00, 1, 32'h103, 32'h0, 1, 2, 32'h100, 4'h8, 32'h0, 32'h80000000,
           32'h0, 4'h0, 32'h0, 32'h0, 32'h00000080, 0));
    add(mk(1, 2'b01, 0, 32'h102, 32'h1234ABCD, 1, 0, 32'h100, 4'hC, 32'hABCD0000, 32'hFFFFFFFF,
           32'h0, 4'h0, 32'h0, 32'h0, 32'h0, 0));
    add(mk(0, 2'b01, 0, 32'h202, 32'h0, 1, 0, 32'h200, 4'hC, 32'h0, 32'h80010000,
           32'h0, 4'h0, 32'h0, 32'h0, 32'hFFFF8001, 0));
    add(mk(0, 2'b01, 1, 32'h200, 32'h0, 1, 1, 32'h200, 4'h3, 32'h0, 32'h1234F00D,
           32'h0, 4'h0, 32'h0, 32'h0, 32'h0000F00D, 0));
    add(mk(1, 2'b00, 0, 32'h301, 32'h000000A5, 1, 0, 32'h300, 4'h2, 32'h0000A500, 32'h0,
           32'h0, 4'h0, 32'h0, 32'h0, 32'h0, 0));
    add(mk(1, 2'b10, 0, 32'h404, 32'hCAFEF00D, 1, 1, 32'h404, 4'hF, 32'hCAFEF00D, 32'h0,
           32'h0, 4'h0, 32'h0, 32'h0, 32'h0, 0));
    add(mk(0, 2'b00, 0, 32'h101, 32'h0, 1, 0, 32'h100, 4'h2, 32'h0, 32'h00007F00,
           32'h0, 4'h0, 32'h0, 32'h0, 32'h0000007F, 0));
    add(mk(0, 2'b11, 0, 32'h100, 32'h0, 0, 0, 32'h0, 4'h0, 32'h0, 32'h0,
           32'h0, 4'h0, 32'h0, 32'h0, 32'h0, 1));
`ifdef LSU_MISALIGN_SPLIT_EN
    add(mk(0, 2'b10, 0, 32'h0FE, 32'h0, 2, 0, 32'h0FC, 4'hC, 32'h0, 32'h22110000,
           32'h100, 4'h3, 32'h0, 32'h00004433, 32'h44332211, 0));
    add(mk(0, 2'b01, 0, 32'hFFFFFFFF, 32'h0, 2, 1, 32'hFFFFFFFC, 4'h8, 32'h0, 32'hAB000000,
           32'h0, 4'h1, 32'h0, 32'h000000CD, 32'hFFFFCDAB, 0));
    add(mk(1, 2'b10, 0, 32'h0FE, 32'h11223344, 2, 0, 32'h0FC, 4'hC, 32'h33440000, 32'h0,
           32'h100, 4'h3, 32'h00001122, 32'h0, 32'h0, 0));
    add(mk(0, 2'b01, 0, 32'h101, 32'h0, 1, 0, 32'h100, 4'h6, 32'h0, 32'h00BEEF00,
           32'h0, 4'h0, 32'h0, 32'h0, 32'hFFFFBEEF, 0));
`else
    add(mk(0, 2'b10, 0, 32'h0FE, 32'h0, 0, 0, 32'h0, 4'h0, 32'h0, 32'h0,
           32'h0, 4'h0, 32'h0, 32'h0, 32'h0, 1));
    add(mk(0, 2'b01, 0, 32'hFFFFFFFF, 32'h0, 0, 0, 32'h0, 4'h0, 32'h0, 32'h0,
           32'h0, 4'h0, 32'h0, 32'h0, 32'h0, 1));
    add(mk(1, 2'b10, 0, 32'h0FE, 32'h11223344, 0, 0, 32'h0, 4'h0, 32'h0, 32'h0,
           32'h0, 4'h0, 32'h0, 32'h0, 32'h0, 1));
    add(mk(0, 2'b01, 0, 32'h101, 32'h0, 0, 0, 32'h0, 4'h0, 32'h0, 32'h0,
           32'h0, 4'h0, 32'h0, 32'h0, 32'h0, 1));
`endif

    for (int i = 0; i < nv; i++) run_vec(vt[i], i);

    // Reset while a beat is in flight: abandoned, no response.
`ifdef LSU_MISALIGN_SPLIT_EN
    issue(1'b0, 2'b10, 1'b0, 32'h0FE, 32'h0);
    mem_ack = 1'b1; mem_rdata = 32'h22110000;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    check("rstmid beat1 addr", mem_addr, 32'h100);
`else
    issue(1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
    @(posedge clk); #1;
    check("rstmid beat0 addr", mem_addr, 32'h100);
`endif
    check("rstmid mem_req before", 32'(mem_req), 32'd1);
    rst = 1'b1;
    #1;
    check("rstmid mem_req async", 32'(mem_req), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      check($sformatf("rstmid rsp_valid c%0d", c), 32'(rsp_valid), 32'd0);
      check($sformatf("rstmid req_ready c%0d", c), 32'(req_ready), 32'd1);
      @(posedge clk); #1;
    end

    run_vec(vt[1], 100);
    check("scoreboard empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
